// File: rtl/alu_128_arbiter.sv
// Round-robin front end that shares one combinational 128-bit ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (ALU settles, capture) -> RESP (hold until taken).
module alu_128_arbiter #(
  parameter int DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DWIDTH-1:0] req0_op1,
  input  logic [DWIDTH-1:0] req0_op2,
  input  logic [3:0]        req0_opcode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DWIDTH-1:0] req1_op1,
  input  logic [DWIDTH-1:0] req1_op2,
  input  logic [3:0]        req1_opcode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DWIDTH-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              cur_id;
  logic              cur_err;
  logic              grant0;
  logic              grant1;
  logic [DWIDTH-1:0] sel_op1;
  logic [DWIDTH-1:0] sel_op2;
  logic [3:0]        sel_opcode;

  // Opcodes with no ALU meaning; their response is forced to zero with rsp_err set.
  function automatic logic illegal_op(input logic [3:0] opc);
    case (opc)
      4'h7, 4'hC, 4'hE, 4'hF: illegal_op = 1'b1;
      default:                illegal_op = 1'b0;
    endcase
  endfunction

  // Grant only in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Request fields of the granted requester.
  always_comb begin
    sel_op1    = req0_op1;
    sel_op2    = req0_op2;
    sel_opcode = req0_opcode;
    if (grant1) begin
      sel_op1    = req1_op1;
      sel_op2    = req1_op2;
      sel_opcode = req1_opcode;
    end else begin
      sel_op1    = req0_op1;
      sel_op2    = req0_op2;
      sel_opcode = req0_opcode;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Sequencer: the alu_* registers double as the latched operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cur_err    <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opsel  <= 3'd0;
      alu_mode   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cur_id     <= grant1;
            last_grant <= grant1;
            cur_err    <= illegal_op(sel_opcode);
            alu_op1    <= sel_op1;
            alu_op2    <= sel_op2;
            alu_opsel  <= sel_opcode[2:0];
            alu_mode   <= sel_opcode[3];
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_id    <= cur_id;
          rsp_err   <= cur_err;
          rsp_valid <= 1'b1;
          if (cur_err) begin
            rsp_result <= '0;
            rsp_flags  <= 4'd0;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_c, alu_z, alu_o, alu_s};
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_128_arbiter.sv
// Directed bench for alu_128_arbiter: a behavioural ALU sits behind the arbiter; accepted
// requests push hand-computed responses into a scoreboard that a response monitor drains.
module tb_alu_128_arbiter;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]    req0_opcode, req1_opcode;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [2:0]    alu_opsel;
  logic          alu_mode, alu_c, alu_z, alu_o, alu_s;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic [3:0]    fl;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t e0, e1;
  logic rsp_log[$];
  logic acc_id[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_128_arbiter #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_opcode(req1_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o), .alu_s(alu_s)
  );

  // Behavioural ALU: c is carry-out (borrow for subtracts, msb out for shl).
  logic [DW:0] t;
  always_comb begin
    t     = '0;
    alu_o = 1'b0;
    case ({alu_mode, alu_opsel})
      4'h0: begin
        t = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_o = (alu_op1[DW-1] == alu_op2[DW-1]) && (t[DW-1] != alu_op1[DW-1]);
      end
      4'h1: begin
        t = {1'b0, alu_op1} - {1'b0, alu_op2} - {{DW{1'b0}}, 1'b1};
        alu_o = (alu_op1[DW-1] != alu_op2[DW-1]) && (t[DW-1] != alu_op1[DW-1]);
      end
      4'h2: t = {1'b0, alu_op1};
      4'h3: begin
        t = {1'b0, alu_op1} - {1'b0, alu_op2};
        alu_o = (alu_op1[DW-1] != alu_op2[DW-1]) && (t[DW-1] != alu_op1[DW-1]);
      end
      4'h4: begin
        t = {1'b0, alu_op1} + {{DW{1'b0}}, 1'b1};
        alu_o = !alu_op1[DW-1] && t[DW-1];
      end
      4'h5: begin
        t = {1'b0, alu_op1} - {{DW{1'b0}}, 1'b1};
        alu_o = alu_op1[DW-1] && !t[DW-1];
      end
      4'h6: begin
        t = {1'b0, alu_op1} + {1'b0, alu_op2} + {{DW{1'b0}}, 1'b1};
        alu_o = (alu_op1[DW-1] == alu_op2[DW-1]) && (t[DW-1] != alu_op1[DW-1]);
      end
      4'h8: t = {1'b0, alu_op1 & alu_op2};
      4'h9: t = {1'b0, alu_op1 | alu_op2};
      4'hA: t = {1'b0, alu_op1 ^ alu_op2};
      4'hB: t = {1'b0, ~alu_op1};
      4'hD: t = {alu_op1, 1'b0};
      default: t = '0;
    endcase
    alu_result = t[DW-1:0];
    alu_c      = t[DW];
    alu_z      = (t[DW-1:0] == '0);
    alu_s      = t[DW-1];
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Record accepts and push the expected response of the accepted requester.
  always @(negedge clk) begin
    if (!rst && req0_valid && req0_ready) begin
      sb.push_back(e0);
      acc_id.push_back(1'b0);
      acc_cyc.push_back(cyc);
    end
    if (!rst && req1_valid && req1_ready) begin
      sb.push_back(e1);
      acc_id.push_back(1'b1);
      acc_cyc.push_back(cyc);
    end
  end

  // Response monitor: compares every completed response handshake with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_log.push_back(rsp_id);
      if (sb.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", DW'(rsp_id), DW'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", DW'(rsp_flags), DW'(e.fl));
        check("rsp_err", DW'(rsp_err), DW'(e.err));
      end
    end
  end

  task automatic send(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [3:0] opc, input logic [DW-1:0] eres,
                      input logic [3:0] efl, input logic eerr);
    bit got;
    got = 1'b0;
    if (id == 1'b0) begin
      req0_op1 = a; req0_op2 = b; req0_opcode = opc;
      e0 = '{id: 1'b0, res: eres, fl: efl, err: eerr};
      req0_valid = 1'b1;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_opcode = opc;
      e1 = '{id: 1'b1, res: eres, fl: efl, err: eerr};
      req1_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(id ? "accept_timeout_req1" : "accept_timeout_req0");
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op1 = DW'(5); req0_op2 = DW'(7); req0_opcode = 4'h0;
    req1_op1 = DW'(8'hF0); req1_op2 = DW'(8'h3C); req1_opcode = 4'h8;

    // Reset held two cycles with requests pending.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_req0_ready", DW'(req0_ready), DW'(0));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_alu_op1", alu_op1, DW'(0));
      check("rst_alu_op2", alu_op2, DW'(0));
      check("rst_alu_opc", DW'({alu_mode, alu_opsel}), DW'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First grant goes to req0 (add 5+7), req1 (and) follows; latency check.
    fork
      send(1'b0, DW'(5), DW'(7), 4'h0, DW'(12), 4'b0000, 1'b0);
      send(1'b1, DW'(8'hF0), DW'(8'h3C), 4'h8, DW'(8'h30), 4'b0000, 1'b0);
      begin
        @(negedge clk);
        check("first_grant_req0", DW'(req0_ready), DW'(1));
        check("first_grant_req1", DW'(req1_ready), DW'(0));
        @(negedge clk);
        check("lat_exec_no_valid", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        check("lat_resp_valid", DW'(rsp_valid), DW'(1));
        check("lat_resp_id", DW'(rsp_id), DW'(0));
      end
    join
    drain();

    // Fairness under continuous dual requests.
    acc_id.delete(); acc_cyc.delete(); rsp_log.delete();
    fork
      begin
        send(1'b0, {1'b0, {(DW-1){1'b1}}}, DW'(1), 4'h0, {1'b1, {(DW-1){1'b0}}}, 4'b0011, 1'b0);
        send(1'b0, DW'(8'h55), DW'(8'h99), 4'h2, DW'(8'h55), 4'b0000, 1'b0);
        send(1'b0, DW'(8'hFF), DW'(8'h0F), 4'hA, DW'(8'hF0), 4'b0000, 1'b0);
      end
      begin
        send(1'b1, {1'b1, {(DW-1){1'b0}}}, DW'(0), 4'hD, DW'(0), 4'b1100, 1'b0);
        send(1'b1, DW'(0), DW'(0), 4'hB, {DW{1'b1}}, 4'b0001, 1'b0);
        send(1'b1, DW'(0), DW'(0), 4'h5, {DW{1'b1}}, 4'b1001, 1'b0);
      end
    join
    drain();
    check("fair_accepts", DW'(acc_id.size()), DW'(6));
    check("fair_responses", DW'(rsp_log.size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < acc_id.size()) check("fair_grant_order", DW'(acc_id[i]), DW'(i % 2));
      if (i < rsp_log.size()) check("fair_rsp_order", DW'(rsp_log[i]), DW'(i % 2));
      if (i + 1 < acc_cyc.size()) check("fair_spacing", DW'(acc_cyc[i+1] - acc_cyc[i]), DW'(3));
    end

    // Backpressure: response held 5 extra cycles while req1 waits.
    rsp_ready = 1'b0;
    fork
      send(1'b0, DW'(8'h0F), DW'(8'hF0), 4'h9, DW'(8'hFF), 4'b0000, 1'b0);
      send(1'b1, DW'(2), DW'(3), 4'h6, DW'(6), 4'b0000, 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (rsp_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) fail_now("bp_rsp_timeout");
        repeat (5) begin
          @(negedge clk);
          check("bp_valid_held", DW'(rsp_valid), DW'(1));
          check("bp_result_held", rsp_result, DW'(8'hFF));
          check("bp_id_held", DW'(rsp_id), DW'(0));
          check("bp_no_ready", DW'({req0_ready, req1_ready}), DW'(0));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after", DW'(req1_ready), DW'(1));
      end
    join
    drain();

    // Zero flag on sub, then an illegal opcode.
    send(1'b1, DW'(3), DW'(3), 4'h3, DW'(0), 4'b0100, 1'b0);
    send(1'b1, DW'(9), DW'(4), 4'hF, DW'(0), 4'b0000, 1'b1);
    drain();

    // Reset while the op is in EXEC: response discarded, req0 wins next.
    send(1'b0, DW'(1), DW'(2), 4'h0, DW'(3), 4'b0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    rsp_log.delete();
    @(negedge clk);
    check("midrst_alu_op1", alu_op1, DW'(0));
    repeat (4) begin
      check("midrst_no_valid", DW'(rsp_valid), DW'(0));
      @(negedge clk);
    end
    check("midrst_no_rsp", DW'(rsp_log.size()), DW'(0));
    @(posedge clk);
    #1;
    acc_id.delete();
    fork
      send(1'b0, DW'(7), DW'(1), 4'h0, DW'(8), 4'b0000, 1'b0);
      send(1'b1, DW'(10), DW'(4), 4'h3, DW'(6), 4'b0000, 1'b0);
    join
    drain();
    check("midrst_accepts", DW'(acc_id.size()), DW'(2));
    if (acc_id.size() > 0) check("midrst_first_grant", DW'(acc_id[0]), DW'(0));
    check("sb_empty", DW'(sb.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
